// File: rtl/iod_delay_step_ctrl.sv
// rtl/iod_delay_step_ctrl.sv - IOD delay-line tap stepping controller (optional IOD_DLY_CTRL_OOR_SYNC_EN)
// Steps a delay line one tap at a time with a fixed idle gap between pulses, tracking tap position.
module iod_delay_step_ctrl #(
    parameter int CNT_W    = 8,
    parameter int STEP_GAP = 4,
    parameter int TAP_MAX  = 127,
    parameter int INIT_TAP = 1
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic             REQ_DIR,
    input  logic [CNT_W-1:0] REQ_STEPS,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] TAP_POS,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_LOAD,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TAP_MAX_C  = CNT_W'(TAP_MAX);
    localparam logic [CNT_W-1:0] INIT_TAP_C = CNT_W'(INIT_TAP);
    localparam logic [3:0]       GAP_LAST   = 4'(STEP_GAP - 1);

    state_t           state;
    logic             live;
    logic             dir_q;
    logic             is_load;
    logic [CNT_W-1:0] remain;
    logic [3:0]       gap_cnt;
    logic             err_q;
    logic [CNT_W-1:0] tap_q;
    logic             oor_s;

`ifdef IOD_DLY_CTRL_OOR_SYNC_EN
    logic oor_m;

    if (STEP_GAP < 3 || STEP_GAP > 15) begin : g_bad_gap
        $error("STEP_GAP must be 3..15 with the range-flag synchronizer");
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            oor_m <= 1'b0;
            oor_s <= 1'b0;
        end else begin
            oor_m <= DELAY_LINE_OUT_OF_RANGE;
            oor_s <= oor_m;
        end
    end
`else
    if (STEP_GAP < 1 || STEP_GAP > 15) begin : g_bad_gap
        $error("STEP_GAP must be 1..15");
    end

    assign oor_s = DELAY_LINE_OUT_OF_RANGE;
`endif

    // A move that would step past either end of the line is refused rather than wrapped.
    function automatic logic blocked(input logic dir, input logic [CNT_W-1:0] tap);
        return dir ? (tap == TAP_MAX_C) : (tap == '0);
    endfunction

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state   <= S_IDLE;
            live    <= 1'b0;
            dir_q   <= 1'b0;
            is_load <= 1'b0;
            remain  <= '0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
            tap_q   <= INIT_TAP_C;
        end else begin
            live <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        err_q   <= 1'b0;
                        is_load <= REQ_LOAD;
                        remain  <= REQ_STEPS;
                        if (REQ_LOAD) begin
                            state <= S_LOAD;
                        end else begin
                            dir_q <= REQ_DIR;
                            if (REQ_STEPS == '0) begin
                                state <= S_DONE;
                            end else if (blocked(REQ_DIR, tap_q)) begin
                                err_q <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_MOVE;
                            end
                        end
                    end
                end
                S_MOVE: begin
                    tap_q   <= dir_q ? tap_q + CNT_W'(1) : tap_q - CNT_W'(1);
                    remain  <= remain - CNT_W'(1);
                    gap_cnt <= GAP_LAST;
                    state   <= S_GAP;
                end
                S_LOAD: begin
                    tap_q   <= INIT_TAP_C;
                    gap_cnt <= GAP_LAST;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (oor_s) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else if (remain == '0 || is_load) begin
                        state <= S_DONE;
                    end else if (blocked(dir_q, tap_q)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_MOVE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // live keeps READY low while reset is held even though the state already reads IDLE.
    assign REQ_READY            = live && (state == S_IDLE);
    assign DONE                 = (state == S_DONE);
    assign ERR                  = err_q;
    assign TAP_POS              = tap_q;
    assign DELAY_LINE_MOVE      = (state == S_MOVE);
    assign DELAY_LINE_LOAD      = (state == S_LOAD);
    assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_iod_delay_step_ctrl.sv
// tb/tb_iod_delay_step_ctrl.sv - directed self-checking bench for iod_delay_step_ctrl
module tb_iod_delay_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_load = 1'b0;
    logic       req_dir = 1'b0;
    logic [7:0] req_steps = 8'd0;
    logic       done;
    logic       err;
    logic [7:0] tap_pos;
    logic       dl_move;
    logic       dl_dir;
    logic       dl_load;
    logic       dl_oor = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int n_move, n_load, load_cyc, done_cyc, both_hi, dir_bad;
    int move_cyc[4];

    iod_delay_step_ctrl dut (
        .FAB_CLK                 (clk),
        .ARST_N                  (rst_n),
        .REQ_VALID               (req_valid),
        .REQ_READY               (req_ready),
        .REQ_LOAD                (req_load),
        .REQ_DIR                 (req_dir),
        .REQ_STEPS               (req_steps),
        .DONE                    (done),
        .ERR                     (err),
        .TAP_POS                 (tap_pos),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_OUT_OF_RANGE (dl_oor)
    );

    always #5 clk = ~clk;

    // Issues one request and records pulses per cycle after the accept edge; range flag driven for cycles oor_from..oor_to.
    task automatic do_req(input logic ld, input logic dr, input int st, input int oor_from, input int oor_to, input int limit);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout: REQ_READY=%0b want 1", req_ready);
        end
        req_valid = 1'b1; req_load = ld; req_dir = dr; req_steps = 8'(st);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_move = 0; n_load = 0; load_cyc = -1; done_cyc = -1; both_hi = 0; dir_bad = 0;
        for (int i = 0; i < 4; i++) move_cyc[i] = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (dl_move) begin
                if (n_move < 4) move_cyc[n_move] = c;
                n_move++;
            end
            if (dl_load) begin
                load_cyc = c;
                n_load++;
            end
            if (dl_move && dl_load) both_hi++;
            if (!ld && dl_dir !== dr) dir_bad++;
            if (done) begin
                done_cyc = c;
                break;
            end
            dl_oor = (c >= oor_from && c <= oor_to);
        end
        dl_oor = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err); end
        n_cmp++; if ({dl_move, dl_load, dl_dir} !== 3'b000) begin n_fail++; $display("FAIL rst_dl: got %b want 000", {dl_move, dl_load, dl_dir}); end
        n_cmp++; if (tap_pos !== 8'd1) begin n_fail++; $display("FAIL rst_tap: got %0d want 1", tap_pos); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_step_up();
        do_req(1'b0, 1'b1, 3, 0, -1, 40);
        n_cmp++; if (n_move !== 3) begin n_fail++; $display("FAIL up3_moves: got %0d want 3", n_move); end
        n_cmp++; if (move_cyc[0] !== 1 || move_cyc[1] !== 6 || move_cyc[2] !== 11) begin n_fail++; $display("FAIL up3_spacing: got %0d,%0d,%0d want 1,6,11", move_cyc[0], move_cyc[1], move_cyc[2]); end
        n_cmp++; if (done_cyc !== 16) begin n_fail++; $display("FAIL up3_done_cyc: got %0d want 16", done_cyc); end
        n_cmp++; if (tap_pos !== 8'd4) begin n_fail++; $display("FAIL up3_tap: got %0d want 4", tap_pos); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL up3_err: got %0b want 0", err); end
        n_cmp++; if (dir_bad !== 0 || both_hi !== 0 || n_load !== 0) begin n_fail++; $display("FAIL up3_misc: dir_bad=%0d both=%0d loads=%0d want 0", dir_bad, both_hi, n_load); end
    endtask

    task automatic test_load();
        do_req(1'b0, 1'b1, 36, 0, -1, 300);
        n_cmp++; if (done_cyc !== 181) begin n_fail++; $display("FAIL up36_done_cyc: got %0d want 181", done_cyc); end
        n_cmp++; if (tap_pos !== 8'd40) begin n_fail++; $display("FAIL up36_tap: got %0d want 40", tap_pos); end
        do_req(1'b1, 1'b0, 9, 0, -1, 20);
        n_cmp++; if (n_load !== 1 || load_cyc !== 1) begin n_fail++; $display("FAIL load_pulse: got %0d at %0d want 1 at 1", n_load, load_cyc); end
        n_cmp++; if (n_move !== 0) begin n_fail++; $display("FAIL load_moves: got %0d want 0", n_move); end
        n_cmp++; if (done_cyc !== 6) begin n_fail++; $display("FAIL load_done_cyc: got %0d want 6", done_cyc); end
        n_cmp++; if (tap_pos !== 8'd1) begin n_fail++; $display("FAIL load_tap: got %0d want 1", tap_pos); end
    endtask

    task automatic test_bound_low();
        do_req(1'b0, 1'b0, 5, 0, -1, 40);
        n_cmp++; if (n_move !== 1 || move_cyc[0] !== 1) begin n_fail++; $display("FAIL low_moves: got %0d want 1", n_move); end
        n_cmp++; if (tap_pos !== 8'd0) begin n_fail++; $display("FAIL low_tap: got %0d want 0", tap_pos); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL low_err: got %0b want 1", err); end
        n_cmp++; if (done_cyc !== 6) begin n_fail++; $display("FAIL low_done_cyc: got %0d want 6", done_cyc); end
        do_req(1'b0, 1'b0, 1, 0, -1, 20);
        n_cmp++; if (n_move !== 0 || done_cyc !== 1) begin n_fail++; $display("FAIL low0_refuse: moves=%0d done=%0d want 0,1", n_move, done_cyc); end
        n_cmp++; if (err !== 1'b1 || tap_pos !== 8'd0) begin n_fail++; $display("FAIL low0_state: err=%0b tap=%0d want 1,0", err, tap_pos); end
    endtask

    task automatic test_zero_steps();
        do_req(1'b0, 1'b1, 0, 0, -1, 20);
        n_cmp++; if (done_cyc !== 1) begin n_fail++; $display("FAIL zero_done_cyc: got %0d want 1", done_cyc); end
        n_cmp++; if (n_move !== 0 || n_load !== 0) begin n_fail++; $display("FAIL zero_pulses: moves=%0d loads=%0d want 0", n_move, n_load); end
        n_cmp++; if (tap_pos !== 8'd0) begin n_fail++; $display("FAIL zero_tap: got %0d want 0", tap_pos); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err_clear: got %0b want 0", err); end
    endtask

    task automatic test_bound_high();
        do_req(1'b0, 1'b1, 127, 0, -1, 700);
        n_cmp++; if (done_cyc !== 636 || tap_pos !== 8'd127) begin n_fail++; $display("FAIL up127: done=%0d tap=%0d want 636,127", done_cyc, tap_pos); end
        do_req(1'b0, 1'b1, 1, 0, -1, 20);
        n_cmp++; if (n_move !== 0 || done_cyc !== 1) begin n_fail++; $display("FAIL high_refuse: moves=%0d done=%0d want 0,1", n_move, done_cyc); end
        n_cmp++; if (err !== 1'b1 || tap_pos !== 8'd127) begin n_fail++; $display("FAIL high_state: err=%0b tap=%0d want 1,127", err, tap_pos); end
    endtask

    task automatic test_oor();
        do_req(1'b0, 1'b0, 4, 7, 10, 40);
        n_cmp++; if (n_move !== 2 || move_cyc[1] !== 6) begin n_fail++; $display("FAIL oor_moves: got %0d want 2", n_move); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %0b want 1", err); end
        n_cmp++; if (done_cyc !== 11) begin n_fail++; $display("FAIL oor_done_cyc: got %0d want 11", done_cyc); end
        n_cmp++; if (tap_pos !== 8'd125) begin n_fail++; $display("FAIL oor_tap: got %0d want 125", tap_pos); end
    endtask

    task automatic test_reset_mid();
        int moves;
        int done_seen;
        moves = 0; done_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_dir = 1'b1; req_steps = 8'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (dl_move) moves++;
            if (done) done_seen++;
        end
        n_cmp++; if (moves !== 2 || dl_dir !== 1'b1) begin n_fail++; $display("FAIL mid_pre: moves=%0d dir=%0b want 2,1", moves, dl_dir); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({done, err, dl_move, dl_load, dl_dir, req_ready} !== 6'b0) begin n_fail++; $display("FAIL mid_outputs: got %b want 000000", {done, err, dl_move, dl_load, dl_dir, req_ready}); end
        n_cmp++; if (tap_pos !== 8'd1) begin n_fail++; $display("FAIL mid_tap: got %0d want 1", tap_pos); end
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done) done_seen++;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b want 1", req_ready); end
        n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", done_seen); end
        n_cmp++; if (tap_pos !== 8'd1) begin n_fail++; $display("FAIL mid_tap_after: got %0d want 1", tap_pos); end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_load();
        test_bound_low();
        test_zero_steps();
        test_bound_high();
        test_oor();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

endmodule
